// File: rtl/reglist_encoder_if.sv
// Handshake/bus bundle for reglist_encoder: start/mask request side and
// index/valid/ready stream side with status outputs.
interface reglist_encoder_if;
    logic        i_start;
    logic [15:0] i_mask;
    logic        i_ready;
    logic        o_busy;
    logic        o_valid;
    logic [3:0]  o_idx;
    logic        o_last;
    logic [4:0]  o_count;
    logic        o_done;

    modport master (
        output i_start, i_mask, i_ready,
        input  o_busy, o_valid, o_idx, o_last, o_count, o_done
    );

    modport slave (
        input  i_start, i_mask, i_ready,
        output o_busy, o_valid, o_idx, o_last, o_count, o_done
    );
endinterface

// File: rtl/reglist_encoder.sv
// Register-list encoder: walks a 16-bit bitmap and streams one 4-bit register
// index per handshake. Define REGLIST_ENC_DESCENDING_EN for highest-first order.
module reglist_encoder (
    input  logic               i_clk,
    input  logic               i_rst,
    reglist_encoder_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_mask;
    logic [15:0] w_mask_nxt;
    logic [4:0]  r_count;
    logic [4:0]  w_count_nxt;
    logic        r_busy;
    logic        r_valid;
    logic [3:0]  r_idx;
    logic        r_last;
    logic        r_done;

    // Selects the next index to emit; iteration order sets priority direction.
    function automatic logic [3:0] f_enc(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
`ifdef REGLIST_ENC_DESCENDING_EN
        for (int i = 0; i < 16; i++) begin
            if (m[i]) idx = i[3:0];
        end
`else
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) idx = i[3:0];
        end
`endif
        return idx;
    endfunction

    function automatic logic [4:0] f_popcount(input logic [15:0] m);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, m[i]};
        end
        return c;
    endfunction

    function automatic logic f_single(input logic [15:0] m);
        return (m != 16'd0) && ((m & (m - 16'd1)) == 16'd0);
    endfunction

    function automatic logic [15:0] f_dec(input logic [3:0] idx);
        return 16'd1 << idx;
    endfunction

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, next remaining mask and next count.
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_mask_nxt  = bus.i_mask;
                    w_count_nxt = f_popcount(bus.i_mask);
                    w_state_nxt = (bus.i_mask != 16'd0) ? S_RUN : S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_valid && bus.i_ready) begin
                    w_mask_nxt  = r_mask & ~f_dec(r_idx);
                    w_state_nxt = r_last ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_mask_nxt  = 16'd0;
                w_count_nxt = 5'd0;
            end
        endcase
    end

    // Outputs are precomputed from next-state values so they stay registered
    // while still presenting the first index one cycle after start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mask  <= 16'd0;
            r_count <= 5'd0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_idx   <= 4'd0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_mask  <= w_mask_nxt;
            r_count <= w_count_nxt;
            r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DONE);
            r_valid <= (w_state_nxt == S_RUN);
            r_idx   <= (w_state_nxt == S_RUN) ? f_enc(w_mask_nxt) : 4'd0;
            r_last  <= (w_state_nxt == S_RUN) && f_single(w_mask_nxt);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.o_busy  = r_busy;
    assign bus.o_valid = r_valid;
    assign bus.o_idx   = r_idx;
    assign bus.o_last  = r_last;
    assign bus.o_count = r_count;
    assign bus.o_done  = r_done;

endmodule

// File: tb/tb_reglist_encoder.sv
// Self-checking bench for reglist_encoder: directed and random masks against
// a list-of-indices reference model (honours REGLIST_ENC_DESCENDING_EN).
module tb_reglist_encoder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    int   q[$];

    reglist_encoder_if bus ();

    reglist_encoder dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: ordered list of set-bit positions.
    task automatic build(input logic [15:0] m);
        q.delete();
        for (int i = 0; i < 16; i++) begin
`ifdef REGLIST_ENC_DESCENDING_EN
            if (m[15-i]) q.push_back(15 - i);
`else
            if (m[i]) q.push_back(i);
`endif
        end
    endtask

    task automatic chk_idle(input string tag, input int ec);
        chk({tag, "_busy"},  32'(bus.o_busy),  32'd0);
        chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
        chk({tag, "_idx"},   32'(bus.o_idx),   32'd0);
        chk({tag, "_last"},  32'(bus.o_last),  32'd0);
        chk({tag, "_done"},  32'(bus.o_done),  32'd0);
        chk({tag, "_count"}, 32'(bus.o_count), 32'(ec));
    endtask

    // mode: 0 ready always, 1 ready toggles 1,0, 2 random ready.
    task automatic run_list(input logic [15:0] m, input int mode, input bit interfere);
        int   pos;
        int   n;
        int   cyc;
        logic r;
        build(m);
        n = q.size();
        bus.i_mask  = m;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        bus.i_mask  = 16'($urandom);
        pos = 0;
        cyc = 0;
        while (pos < n && cyc < 100) begin
            chk("valid", 32'(bus.o_valid), 32'd1);
            chk("idx",   32'(bus.o_idx),   32'(q[pos]));
            chk("last",  32'(bus.o_last),  32'(pos == n - 1));
            chk("busy",  32'(bus.o_busy),  32'd1);
            chk("done",  32'(bus.o_done),  32'd0);
            chk("count", 32'(bus.o_count), 32'(n));
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.i_ready = r;
            if (interfere && cyc < 2) begin
                bus.i_start = 1'b1;
                bus.i_mask  = ~m;
            end
            step();
            bus.i_start = 1'b0;
            if (r) pos++;
            cyc++;
        end
        chk("timeout", 32'(cyc < 100), 32'd1);
        bus.i_ready = 1'b0;
        chk("dn_done",  32'(bus.o_done),  32'd1);
        chk("dn_valid", 32'(bus.o_valid), 32'd0);
        chk("dn_busy",  32'(bus.o_busy),  32'd1);
        chk("dn_idx",   32'(bus.o_idx),   32'd0);
        chk("dn_last",  32'(bus.o_last),  32'd0);
        chk("dn_count", 32'(bus.o_count), 32'(n));
        step();
        chk_idle("post", n);
    endtask

    initial begin
        n_checks    = 0;
        n_err       = 0;
        rst         = 1'b1;
        bus.i_start = 1'b1;
        bus.i_mask  = 16'hFFFF;
        bus.i_ready = 1'b0;
        step();
        step();
        chk_idle("reset", 0);
        rst         = 1'b0;
        bus.i_start = 1'b0;
        step();
        chk_idle("idle", 0);

        run_list(16'h8005, 0, 1'b0);
        run_list(16'h0000, 0, 1'b0);
        run_list(16'hFFFF, 1, 1'b0);
        run_list(16'h1234, 0, 1'b1);

        // Reset after the second handshake abandons the list silently.
        build(16'h0F00);
        bus.i_mask  = 16'h0F00;
        bus.i_start = 1'b1;
        bus.i_ready = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk("r_idx0", 32'(bus.o_idx), 32'(q[0]));
        step();
        chk("r_idx1", 32'(bus.o_idx), 32'(q[1]));
        step();
        chk("r_idx2", 32'(bus.o_idx), 32'(q[2]));
        rst         = 1'b1;
        bus.i_start = 1'b1;
        step();
        chk_idle("mid_rst", 0);
        rst         = 1'b0;
        bus.i_start = 1'b0;
        bus.i_ready = 1'b0;
        step();
        chk_idle("after_rst", 0);
        run_list(16'h0002, 0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            run_list(16'($urandom), 2, k[0]);
        end
        run_list(16'h0001, 2, 1'b0);
        run_list(16'h8000, 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
